bcd_clock_scan_core: RTL and testbench

Parametrised timekeeping core replacing the ad-hoc MM:SS counter and static segment decode in the top level. It holds a 4-digit packed-BCD time (upper field : lower field), advances it from a prescaled tick, and supports synchronous load with validity checking. It also compares against an armed alarm value and drives a time-multiplexed 4-digit 7-segment display. It sits between the service FSMs (load/alarm requests) and the board seg/anode pins.

---
 rtl/bcd_clock_scan_core_if.sv | 27 ++
 rtl/bcd_clock_scan_core.sv | 169 ++++++++++++++++
 tb/tb_bcd_clock_scan_core.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_clock_scan_core_if.sv
// Bus bundle for bcd_clock_scan_core: service-side requests in, time/alarm/display out.
// master = service FSM / board side, slave = the timekeeping core.
interface bcd_clock_scan_core_if;
  logic        tick_en;
  logic        load;
  logic [15:0] load_value;
  logic        alarm_arm;
  logic [15:0] alarm_value;
  logic        alarm_clr;
  logic [15:0] time_bcd;
  logic        tick;
  logic        load_err;
  logic        alarm_armed;
  logic        alarm_hit;
  logic [7:0]  seg;
  logic [3:0]  anode;

  modport master (
    output tick_en, load, load_value, alarm_arm, alarm_value, alarm_clr,
    input  time_bcd, tick, load_err, alarm_armed, alarm_hit, seg, anode
  );

  modport slave (
    input  tick_en, load, load_value, alarm_arm, alarm_value, alarm_clr,
    output time_bcd, tick, load_err, alarm_armed, alarm_hit, seg, anode
  );
endinterface

// File: rtl/bcd_clock_scan_core.sv
// 4-digit packed-BCD timekeeper with validated load, armed alarm and multiplexed 7-seg scan.
// Optional macro ALARM_BLINK_EN: blank the display at a BLINK_DIV-rotation rate while alarm_hit=1.
module bcd_clock_scan_core #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned UPPER_MAX = 59,
  parameter int unsigned BLINK_DIV = 8
) (
  input logic                   clk,
  input logic                   resetn,
  bcd_clock_scan_core_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0]  UMAX_BCD = {4'(UPPER_MAX / 10), 4'(UPPER_MAX % 10)};

  if (TICK_DIV < 1 || SCAN_DIV < 1 || BLINK_DIV < 1 || UPPER_MAX > 99) begin : g_param_check
    $error("bcd_clock_scan_core: illegal parameter value");
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] d0, d1, d2, d3;
    {d3, d2, d1, d0} = t;
    if (d0 != 4'd9) d0 = d0 + 4'd1;
    else begin
      d0 = '0;
      if (d1 != 4'd5) d1 = d1 + 4'd1;
      else begin
        d1 = '0;
        if ({d3, d2} == UMAX_BCD) {d3, d2} = '0;
        else if (d2 != 4'd9) d2 = d2 + 4'd1;
        else begin
          d2 = '0;
          d3 = d3 + 4'd1;
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  // Digit-wise BCD compare of the upper field is numerically ordered once each digit is <= 9.
  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9) &&
           (v[15:12] <= 4'd9) && (v[15:8] <= UMAX_BCD);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [15:0]   time_q, time_d, alarm_q, alarm_d, time_inc;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic          tick_q, tick_d, lerr_q, lerr_d, armed_q, armed_d, hit_q, hit_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    anode_q, anode_d, digit;
  logic          pre_wrap, scan_wrap, adv;
`ifdef ALARM_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
`endif

  always_comb begin
    time_d    = time_q;
    pre_d     = pre_q;
    lerr_d    = 1'b0;
    time_inc  = bcd_inc(time_q);
    pre_wrap  = (pre_q == PW'(TICK_DIV - 1));
    // Any load request, valid or not, blocks the prescaler and time advance for this cycle.
    adv       = bus.tick_en && !bus.load && pre_wrap;
    tick_d    = adv;
    if (bus.load) begin
      if (bcd_valid(bus.load_value)) begin
        time_d = bus.load_value;
        pre_d  = '0;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (bus.tick_en) begin
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
      if (pre_wrap) time_d = time_inc;
    end

    armed_d = armed_q | bus.alarm_arm;
    alarm_d = bus.alarm_arm ? bus.alarm_value : alarm_q;
    hit_d   = bus.alarm_clr ? 1'b0 : (hit_q | (armed_q && adv && (time_inc == alarm_q)));

    scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    digit     = time_q[{idx_q, 2'b00} +: 4];
    seg_d     = {idx_q == 2'd2, seg7(digit)};
    anode_d   = ~(4'b0001 << idx_q);
`ifdef ALARM_BLINK_EN
    blink_d = blink_q;
    phase_d = phase_q;
    if (scan_wrap && idx_q == 2'd3) begin
      if (blink_q == BW'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    if (bus.alarm_clr) phase_d = 1'b0;
    if (hit_q && phase_q) anode_d = '1;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_q  <= '0;
      alarm_q <= '0;
      pre_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      lerr_q  <= 1'b0;
      armed_q <= 1'b0;
      hit_q   <= 1'b0;
      seg_q   <= 8'b00111111;
      anode_q <= 4'b1110;
`ifdef ALARM_BLINK_EN
      blink_q <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      time_q  <= time_d;
      alarm_q <= alarm_d;
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      lerr_q  <= lerr_d;
      armed_q <= armed_d;
      hit_q   <= hit_d;
      seg_q   <= seg_d;
      anode_q <= anode_d;
`ifdef ALARM_BLINK_EN
      blink_q <= blink_d;
      phase_q <= phase_d;
`endif
    end
  end

  assign bus.time_bcd    = time_q;
  assign bus.tick        = tick_q;
  assign bus.load_err    = lerr_q;
  assign bus.alarm_armed = armed_q;
  assign bus.alarm_hit   = hit_q;
  assign bus.seg         = seg_q;
  assign bus.anode       = anode_q;

endmodule

// File: tb/tb_bcd_clock_scan_core.sv
// Self-checking bench: two core instances (MM:SS fast tick, HH:MM divided tick) against a decimal reference model.
module tb_bcd_clock_scan_core;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bcd_clock_scan_core_if bif0 ();
  bcd_clock_scan_core_if bif1 ();

  bcd_clock_scan_core #(.TICK_DIV(1), .SCAN_DIV(2), .UPPER_MAX(59), .BLINK_DIV(8))
    dut0 (.clk(clk), .resetn(resetn), .bus(bif0));
  bcd_clock_scan_core #(.TICK_DIV(3), .SCAN_DIV(4), .UPPER_MAX(23), .BLINK_DIV(8))
    dut1 (.clk(clk), .resetn(resetn), .bus(bif1));

  int checks = 0;
  int failures = 0;

  int TD[2] = '{1, 3};
  int SD[2] = '{2, 4};
  int UM[2] = '{59, 23};
  logic [6:0] SEGTAB[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state: time kept as two decimal integers (upper, lower).
  int          m_up[2], m_lo[2], m_pre[2], m_n[2];
  logic [15:0] m_al[2];
  bit          m_armed[2], m_hit[2], m_tick[2], m_lerr[2];
  logic [3:0]  m_an[2];
  logic [7:0]  m_seg[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int up, input int lo);
    return {4'(up / 10), 4'(up % 10), 4'(lo / 10), 4'(lo % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_up[k] = 0; m_lo[k] = 0; m_pre[k] = 0; m_n[k] = 0; m_al[k] = '0;
      m_armed[k] = 0; m_hit[k] = 0; m_tick[k] = 0; m_lerr[k] = 0;
      m_an[k] = 4'b1110; m_seg[k] = 8'h3F;
    end
  endtask

  task automatic model_step(input int k, input logic ld, input logic [15:0] lv, input logic ten,
                            input logic arm, input logic [15:0] av, input logic clr);
    logic [15:0] tb4;
    int idx, dig, d0, d1, d2, d3;
    bit ok, set;
    tb4 = to_bcd(m_up[k], m_lo[k]);
    idx = (m_n[k] / SD[k]) % 4;
    dig = int'((tb4 >> (4 * idx)) & 16'hF);
    m_an[k]  = ~(4'b0001 << idx);
    m_seg[k] = {idx == 2, SEGTAB[dig]};
    m_n[k]++;
    m_tick[k] = 0; m_lerr[k] = 0; set = 0;
    d3 = int'(lv[15:12]); d2 = int'(lv[11:8]); d1 = int'(lv[7:4]); d0 = int'(lv[3:0]);
    ok = d0 <= 9 && d1 <= 5 && d2 <= 9 && d3 <= 9 && (d3 * 10 + d2) <= UM[k];
    if (ld) begin
      if (ok) begin
        m_up[k] = d3 * 10 + d2; m_lo[k] = d1 * 10 + d0; m_pre[k] = 0;
      end else m_lerr[k] = 1;
    end else if (ten) begin
      if (m_pre[k] == TD[k] - 1) begin
        m_pre[k] = 0; m_tick[k] = 1;
        m_lo[k]++;
        if (m_lo[k] == 60) begin
          m_lo[k] = 0;
          m_up[k] = (m_up[k] == UM[k]) ? 0 : m_up[k] + 1;
        end
        set = m_armed[k] && (to_bcd(m_up[k], m_lo[k]) == m_al[k]);
      end else m_pre[k]++;
    end
    m_hit[k] = clr ? 0 : (m_hit[k] | set);
    if (arm) begin
      m_armed[k] = 1; m_al[k] = av;
    end
  endtask

  task automatic cmp_inst(input string p, input int k, input logic [15:0] t, input logic tk,
                          input logic le, input logic ar, input logic hi,
                          input logic [3:0] an, input logic [7:0] sg);
    chk({p, "_time"}, t, to_bcd(m_up[k], m_lo[k]));
    chk({p, "_tick"}, tk, m_tick[k]);
    chk({p, "_load_err"}, le, m_lerr[k]);
    chk({p, "_armed"}, ar, m_armed[k]);
    chk({p, "_hit"}, hi, m_hit[k]);
    chk({p, "_anode"}, an, m_an[k]);
    chk({p, "_seg"}, sg, m_seg[k]);
  endtask

  task automatic compare_all();
    cmp_inst("u0", 0, bif0.time_bcd, bif0.tick, bif0.load_err, bif0.alarm_armed, bif0.alarm_hit,
             bif0.anode, bif0.seg);
    cmp_inst("u1", 1, bif1.time_bcd, bif1.tick, bif1.load_err, bif1.alarm_armed, bif1.alarm_hit,
             bif1.anode, bif1.seg);
  endtask

  task automatic cycle(input logic ld, input logic [15:0] lv, input logic ten,
                       input logic arm, input logic [15:0] av, input logic clr);
    bif0.load = ld; bif0.load_value = lv; bif0.tick_en = ten;
    bif0.alarm_arm = arm; bif0.alarm_value = av; bif0.alarm_clr = clr;
    bif1.load = ld; bif1.load_value = lv; bif1.tick_en = ten;
    bif1.alarm_arm = arm; bif1.alarm_value = av; bif1.alarm_clr = clr;
    model_step(0, ld, lv, ten, arm, av, clr);
    model_step(1, ld, lv, ten, arm, av, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        ten, arm;
    logic [15:0] av;
    logic        clr;
    logic [15:0] e_time;
    logic        e_tick, e_lerr, e_hit;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[4];
    logic [7:0] es;
    // Expected outputs of the TICK_DIV=1 / UPPER_MAX=59 instance, one row per clock.
    tbl.push_back('{1'b1, 16'h5958, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5958, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h5959, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h1260, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h2400, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h2400, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h2400, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h2402, 1'b0, 16'h2401, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h2402, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h2402, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2402, 1'b0, 1'b0, 1'b0});

    resetn = 1'b0;
    bif0.load = 0; bif0.load_value = '0; bif0.tick_en = 0;
    bif0.alarm_arm = 0; bif0.alarm_value = '0; bif0.alarm_clr = 0;
    bif1.load = 0; bif1.load_value = '0; bif1.tick_en = 0;
    bif1.alarm_arm = 0; bif1.alarm_value = '0; bif1.alarm_clr = 0;
    model_reset();
    #23;
    compare_all();
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].ld, tbl[i].lv, tbl[i].ten, tbl[i].arm, tbl[i].av, tbl[i].clr);
      chk($sformatf("vec%0d_time", i), bif0.time_bcd, tbl[i].e_time);
      chk($sformatf("vec%0d_tick", i), bif0.tick, tbl[i].e_tick);
      chk($sformatf("vec%0d_load_err", i), bif0.load_err, tbl[i].e_lerr);
      chk($sformatf("vec%0d_hit", i), bif0.alarm_hit, tbl[i].e_hit);
    end

    // TICK_DIV=3 instance: tick period and tick_en freeze.
    cycle(1, 16'h0959, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 16'h0, 1, 0, 16'h0, 0);
      chk($sformatf("div3_time_%0d", i), bif1.time_bcd, (i == 3) ? 16'h1000 : 16'h0959);
      chk($sformatf("div3_tick_%0d", i), bif1.tick, (i == 3) ? 1 : 0);
    end
    cycle(0, 16'h0, 1, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 16'h0, 0, 0, 16'h0, 0);
      chk("freeze_time", bif1.time_bcd, 16'h1000);
      chk("freeze_tick", bif1.tick, 0);
    end
    cycle(0, 16'h0, 1, 0, 16'h0, 0);
    chk("resume_no_tick", bif1.tick, 0);
    cycle(0, 16'h0, 1, 0, 16'h0, 0);
    chk("resume_time", bif1.time_bcd, 16'h1001);
    chk("resume_tick", bif1.tick, 1);

    // UPPER_MAX=23 instance: 2359 wraps to 0000; 2400 rejected.
    cycle(1, 16'h2359, 0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 16'h0, 1, 0, 16'h0, 0);
    chk("hhmm_wrap", bif1.time_bcd, 16'h0000);
    cycle(1, 16'h2400, 0, 0, 16'h0, 0);
    chk("hhmm_2400_err", bif1.load_err, 1);
    chk("hhmm_2400_time", bif1.time_bcd, 16'h0000);

    // Scan of 1234 on the SCAN_DIV=2 instance.
    cycle(1, 16'h1234, 0, 0, 16'h0, 0);
    cycle(0, 16'h0, 0, 0, 16'h0, 0);
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cycle(0, 16'h0, 0, 0, 16'h0, 0);
      case (bif0.anode)
        4'b1110: begin es = 8'h66; cnt[0]++; end
        4'b1101: begin es = 8'h4F; cnt[1]++; end
        4'b1011: begin es = 8'hDB; cnt[2]++; end
        4'b0111: begin es = 8'h06; cnt[3]++; end
        default: es = 8'h00;
      endcase
      chk("scan_seg", bif0.seg, es);
    end
    for (int d = 0; d < 4; d++) chk($sformatf("scan_hold_d%0d", d), cnt[d], 2);

    // Asynchronous reset mid-scan.
    cycle(0, 16'h0, 1, 0, 16'h0, 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_anode", bif0.anode, 4'b1110);
    chk("rst_seg", bif0.seg, 8'h3F);
    chk("rst_time0", bif0.time_bcd, 16'h0000);
    chk("rst_time1", bif1.time_bcd, 16'h0000);
    model_reset();
    #2;
    resetn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic ld, ten, arm, clr;
      logic [15:0] lv, av;
      ld  = ($urandom % 16) == 0;
      lv  = ($urandom % 2) ? to_bcd(int'($urandom % 24), int'($urandom % 60)) : 16'($urandom);
      ten = ($urandom % 8) != 0;
      arm = ($urandom % 32) == 0;
      av  = to_bcd(m_up[0], (m_lo[0] + int'($urandom % 5)) % 60);
      clr = ($urandom % 64) == 0;
      cycle(ld, lv, ten, arm, av, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
